cvm_change_dispenser: RTL and testbench

//  Downstream stage of the coin vending machine FSM. Queues the single-cycle del/rn/rd

---
 rtl/cvm_change_dispenser_if.sv | 26 ++
 rtl/cvm_change_dispenser.sv | 148 ++++++++++++++
 tb/tb_cvm_change_dispenser.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cvm_change_dispenser_if.sv
// Strobe, sensor and solenoid bundle between the vending FSM/mechanics and the
// change dispenser. The master side issues strobes and reports sensors.
interface cvm_change_dispenser_if;
    logic del;
    logic rn;
    logic rd;
    logic clr_fault;
    logic vend_seen;
    logic coin_seen;
    logic vend_sol;
    logic nick_sol;
    logic dime_sol;
    logic busy;
    logic fault;
    logic ovf;

    modport master (
        output del, rn, rd, clr_fault, vend_seen, coin_seen,
        input  vend_sol, nick_sol, dime_sol, busy, fault, ovf
    );

    modport slave (
        input  del, rn, rd, clr_fault, vend_seen, coin_seen,
        output vend_sol, nick_sol, dime_sol, busy, fault, ovf
    );
endinterface

// File: rtl/cvm_change_dispenser.sv
// Queues product/nickel/dime strobes and actuates one solenoid at a time,
// waiting for drop-sensor confirmation; a missing confirmation latches a fault.
module cvm_change_dispenser #(
    parameter int CNT_W       = 3,
    parameter int PULSE_CYC   = 4,
    parameter int TIMEOUT_CYC = 16,
    parameter int TMR_W       = 5
) (
    input  logic                   clk,
    input  logic                   rst_,
    cvm_change_dispenser_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, PULSE, WAIT, FAULT} state_t;
    // Encoding doubles as the index into the per-type vectors below.
    typedef enum logic [1:0] {SEL_V = 2'd0, SEL_D = 2'd1, SEL_N = 2'd2} sel_t;

    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [TMR_W-1:0] PULSE_LAST   = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYC - 1);

    state_t                     state_reg, state_next;
    sel_t                       sel_reg, sel_next;
    logic [TMR_W-1:0]           timer_reg, timer_next;
    logic [2:0]                 sol_reg, sol_next;
    logic                       fault_reg, fault_next;
    logic                       ovf_reg, ovf_next;
    logic [2:0][CNT_W-1:0]      pend_reg, pend_next;

    logic [2:0]                 strobe;
    logic [2:0]                 sat;
    logic [2:0]                 inc;
    logic [2:0]                 confirm;
    logic [2:0]                 pend_nz;
    logic                       sensor;

    function automatic logic [2:0] sel_onehot(input sel_t s);
        case (s)
            SEL_V:   sel_onehot = 3'b001;
            SEL_D:   sel_onehot = 3'b010;
            SEL_N:   sel_onehot = 3'b100;
            default: sel_onehot = 3'b000;
        endcase
    endfunction

    assign strobe = {bus.rn, bus.rd, bus.del};

    // Pending counters: saturating, and an increment plus a confirmation cancel out.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            assign sat[gi]       = (pend_reg[gi] == CNT_MAX);
            assign inc[gi]       = strobe[gi] & ~sat[gi];
            assign pend_nz[gi]   = |pend_reg[gi];
            assign pend_next[gi] = (inc[gi] && !confirm[gi]) ? pend_reg[gi] + CNT_W'(1) :
                                   (!inc[gi] && confirm[gi]) ? pend_reg[gi] - CNT_W'(1) :
                                                               pend_reg[gi];
        end
    endgenerate

    assign sensor = (sel_reg == SEL_V) ? bus.vend_seen : bus.coin_seen;

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        timer_next = timer_reg;
        sol_next   = 3'b000;
        fault_next = fault_reg;
        confirm    = 3'b000;

        case (state_reg)
            IDLE: begin
                if (|pend_nz) begin
                    if (pend_nz[SEL_V])      sel_next = SEL_V;
                    else if (pend_nz[SEL_D]) sel_next = SEL_D;
                    else                     sel_next = SEL_N;
                    state_next = PULSE;
                    timer_next = '0;
                    sol_next   = sel_onehot(sel_next);
                end
            end
            PULSE: begin
                if (timer_reg == PULSE_LAST) begin
                    state_next = WAIT;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                    sol_next   = sel_onehot(sel_reg);
                end
            end
            WAIT: begin
                if (sensor) begin
                    confirm    = sel_onehot(sel_reg);
                    state_next = IDLE;
                end else if (timer_reg == TIMEOUT_LAST) begin
                    state_next = FAULT;
                    fault_next = 1'b1;
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end
            FAULT: begin
                if (bus.clr_fault) begin
                    fault_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A saturated strobe in the same cycle as clr_fault still reports overflow.
    always_comb begin
        ovf_next = ovf_reg;
        if (bus.clr_fault)
            ovf_next = 1'b0;
        if (|(strobe & sat))
            ovf_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_reg <= IDLE;
            sel_reg   <= SEL_V;
            timer_reg <= '0;
            sol_reg   <= 3'b000;
            fault_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            pend_reg  <= '0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            timer_reg <= timer_next;
            sol_reg   <= sol_next;
            fault_reg <= fault_next;
            ovf_reg   <= ovf_next;
            pend_reg  <= pend_next;
        end
    end

    assign bus.vend_sol = sol_reg[SEL_V];
    assign bus.dime_sol = sol_reg[SEL_D];
    assign bus.nick_sol = sol_reg[SEL_N];
    assign bus.fault    = fault_reg;
    assign bus.ovf      = ovf_reg;
    assign bus.busy     = (state_reg != IDLE) || (|pend_nz);

endmodule

// File: tb/tb_cvm_change_dispenser.sv
// Directed bench for the change dispenser: latency, ordering, timeout/fault,
// saturation and asynchronous reset behaviour.
module tb_cvm_change_dispenser;

    logic clk  = 1'b0;
    logic rst_ = 1'b0;

    always #5 clk = ~clk;

    cvm_change_dispenser_if bus();

    cvm_change_dispenser #(
        .CNT_W(3), .PULSE_CYC(4), .TIMEOUT_CYC(16), .TMR_W(5)
    ) dut (
        .clk (clk),
        .rst_(rst_),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Solenoid activity log and automatic sensor responder.
    logic       auto_resp = 1'b0;
    logic       prev_v = 1'b0, prev_n = 1'b0, prev_d = 1'b0;
    int         v_pulses, n_pulses, d_pulses, overlap;
    logic [1:0] seq_log [8];
    int         seq_n;
    int         d_lens [4];
    int         d_len_n, d_run;

    always @(posedge clk) begin
        #2;
        if (32'(bus.vend_sol) + 32'(bus.nick_sol) + 32'(bus.dime_sol) > 1) overlap++;
        if (bus.vend_sol && !prev_v) begin
            v_pulses++;
            if (seq_n < 8) begin seq_log[seq_n] = 2'd1; seq_n++; end
        end
        if (bus.dime_sol && !prev_d) begin
            d_pulses++;
            if (seq_n < 8) begin seq_log[seq_n] = 2'd2; seq_n++; end
        end
        if (bus.nick_sol && !prev_n) begin
            n_pulses++;
            if (seq_n < 8) begin seq_log[seq_n] = 2'd3; seq_n++; end
        end
        if (bus.dime_sol) d_run++;
        else if (prev_d) begin
            if (d_len_n < 4) begin d_lens[d_len_n] = d_run; d_len_n++; end
            d_run = 0;
        end
        if (auto_resp) begin
            bus.vend_seen = prev_v && !bus.vend_sol;
            bus.coin_seen = (prev_n && !bus.nick_sol) || (prev_d && !bus.dime_sol);
        end
        prev_v = bus.vend_sol;
        prev_n = bus.nick_sol;
        prev_d = bus.dime_sol;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // s[0]=del, s[1]=rd, s[2]=rn, held for one cycle
    task automatic strobe(input logic [2:0] s);
        bus.del = s[0];
        bus.rd  = s[1];
        bus.rn  = s[2];
        tick();
        bus.del = 1'b0;
        bus.rd  = 1'b0;
        bus.rn  = 1'b0;
    endtask

    task automatic clear_log();
        v_pulses = 0; n_pulses = 0; d_pulses = 0; overlap = 0;
        seq_n = 0; d_len_n = 0; d_run = 0;
        for (int i = 0; i < 8; i++) seq_log[i] = 2'd0;
        for (int i = 0; i < 4; i++) d_lens[i] = 0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n = 0;
        while (bus.busy && n < max_cyc) begin
            tick();
            n++;
        end
        bus.vend_seen = 1'b0;
        bus.coin_seen = 1'b0;
        chk(tag, 32'(bus.busy), 0);
    endtask

    task automatic wait_nick(input logic lvl, input string tag);
        int n = 0;
        while (bus.nick_sol !== lvl && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.nick_sol), 32'(lvl));
    endtask

    initial begin
        bus.del = 1'b0; bus.rn = 1'b0; bus.rd = 1'b0; bus.clr_fault = 1'b0;
        bus.vend_seen = 1'b0; bus.coin_seen = 1'b0;
        clear_log();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sols", {29'd0, bus.vend_sol, bus.dime_sol, bus.nick_sol}, 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_fault", 32'(bus.fault), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        rst_ = 1'b1;
        tick();

        // Single dime, sensor two cycles after release
        strobe(3'b010);
        chk("t2_pend_d_1", 32'(dut.pend_reg[1]), 1);
        chk("t2_dime_early", 32'(bus.dime_sol), 0);
        chk("t2_busy", 32'(bus.busy), 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_dime_on%0d", i), 32'(bus.dime_sol), 1);
            tick();
        end
        chk("t2_dime_off", 32'(bus.dime_sol), 0);
        chk("t2_pend_d_wait", 32'(dut.pend_reg[1]), 1);
        tick();
        tick();
        chk("t2_busy_wait", 32'(bus.busy), 1);
        bus.coin_seen = 1'b1;
        tick();
        bus.coin_seen = 1'b0;
        chk("t2_pend_d_0", 32'(dut.pend_reg[1]), 0);
        chk("t2_busy_low", 32'(bus.busy), 0);
        chk("t2_fault", 32'(bus.fault), 0);

        // del, rd, rn two cycles apart
        clear_log();
        auto_resp = 1'b1;
        strobe(3'b001);
        tick();
        strobe(3'b010);
        tick();
        strobe(3'b100);
        wait_idle("t3_done", 200);
        chk("t3_v_pulses", 32'(v_pulses), 1);
        chk("t3_d_pulses", 32'(d_pulses), 1);
        chk("t3_n_pulses", 32'(n_pulses), 1);
        chk("t3_first", 32'(seq_log[0]), 1);
        chk("t3_second", 32'(seq_log[1]), 2);
        chk("t3_third", 32'(seq_log[2]), 3);
        chk("t3_overlap", 32'(overlap), 0);

        // Two dimes three cycles apart
        clear_log();
        strobe(3'b010);
        tick();
        tick();
        strobe(3'b010);
        wait_idle("t4_done", 200);
        chk("t4_d_pulses", 32'(d_pulses), 2);
        chk("t4_len0", 32'(d_lens[0]), 4);
        chk("t4_len1", 32'(d_lens[1]), 4);
        chk("t4_pend_d", 32'(dut.pend_reg[1]), 0);

        // Nickel with no confirmation -> fault after 16 WAIT cycles
        clear_log();
        auto_resp = 1'b0;
        bus.coin_seen = 1'b0;
        bus.vend_seen = 1'b0;
        strobe(3'b100);
        tick();
        chk("t5_nick_on", 32'(bus.nick_sol), 1);
        repeat (3) tick();
        chk("t5_nick_on_last", 32'(bus.nick_sol), 1);
        tick();
        chk("t5_nick_off", 32'(bus.nick_sol), 0);
        repeat (15) tick();
        chk("t5_fault_pre", 32'(bus.fault), 0);
        tick();
        chk("t5_fault", 32'(bus.fault), 1);
        chk("t5_pend_n", 32'(dut.pend_reg[2]), 1);
        chk("t5_n_pulses", 32'(n_pulses), 1);

        // Strobes keep queueing in FAULT and saturate
        repeat (8) strobe(3'b100);
        chk("t6_pend_n_sat", 32'(dut.pend_reg[2]), 7);
        chk("t6_ovf", 32'(bus.ovf), 1);
        chk("t6_fault_held", 32'(bus.fault), 1);
        chk("t6_no_pulse", 32'(n_pulses), 1);

        // Clear fault: retry and drain the queue
        clear_log();
        auto_resp = 1'b1;
        bus.clr_fault = 1'b1;
        tick();
        bus.clr_fault = 1'b0;
        chk("t5_fault_clr", 32'(bus.fault), 0);
        chk("t5_ovf_clr", 32'(bus.ovf), 0);
        wait_idle("t5_done", 300);
        chk("t5_pend_n_0", 32'(dut.pend_reg[2]), 0);
        chk("t5_n_repulses", 32'(n_pulses), 7);

        // rn strobe in the same cycle as a nickel confirmation
        auto_resp = 1'b0;
        strobe(3'b100);
        wait_nick(1'b1, "t6_rise");
        wait_nick(1'b0, "t6_fall");
        chk("t6_pend_pre", 32'(dut.pend_reg[2]), 1);
        bus.coin_seen = 1'b1;
        bus.rn = 1'b1;
        tick();
        bus.coin_seen = 1'b0;
        bus.rn = 1'b0;
        chk("t6_pend_same", 32'(dut.pend_reg[2]), 1);
        chk("t6_fault_none", 32'(bus.fault), 0);
        auto_resp = 1'b1;
        wait_idle("t6_done", 100);
        chk("t6_pend_n_0", 32'(dut.pend_reg[2]), 0);

        // Asynchronous reset in the middle of a nickel pulse
        auto_resp = 1'b0;
        strobe(3'b100);
        tick();
        strobe(3'b110);
        chk("t1_nick_on", 32'(bus.nick_sol), 1);
        chk("t1_pend_n", 32'(dut.pend_reg[2]), 2);
        chk("t1_pend_d", 32'(dut.pend_reg[1]), 1);
        #3;
        rst_ = 1'b0;
        #1;
        chk("t1_nick_async", 32'(bus.nick_sol), 0);
        chk("t1_pend_all", 32'({dut.pend_reg[0], dut.pend_reg[1], dut.pend_reg[2]}), 0);
        chk("t1_fault", 32'(bus.fault), 0);
        chk("t1_ovf", 32'(bus.ovf), 0);
        chk("t1_busy", 32'(bus.busy), 0);
        tick();
        chk("t1_sols_held", {29'd0, bus.vend_sol, bus.dime_sol, bus.nick_sol}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
